// File: rtl/led_seq_pkg.sv
`default_nettype none
// led_seq_pkg: sequencer states, playlist entry layout and the table's power-on contents.
// Optional manual-step feature of the top is enabled by LED_SEQ_MANUAL_STEP_EN.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_e;

  localparam int ENTRIES          = 8;
  localparam int IDX_W            = 3;
  localparam int ENTRY_W          = 8;
  localparam int PAT_LSB          = 0;
  localparam int PAT_W            = 3;
  localparam int SPEED_BIT        = 3;
  localparam int DWELL_LSB        = 4;
  localparam int DWELL_W          = 4;
  localparam int DWELL_ZERO_MEANS = 16;
  localparam int DWELL_CNT_W      = 5;

  function automatic logic [ENTRY_W-1:0] table_reset_value(input logic [IDX_W-1:0] idx);
    return {4'd1, 1'b0, idx};
  endfunction

  // A zero dwell field encodes the longest dwell rather than "skip".
  function automatic logic [DWELL_CNT_W-1:0] dwell_ticks(input logic [ENTRY_W-1:0] entry);
    logic [DWELL_W-1:0] d;
    d = entry[DWELL_LSB +: DWELL_W];
    return (d == '0) ? DWELL_CNT_W'(DWELL_ZERO_MEANS) : DWELL_CNT_W'(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_prescaler.sv
`default_nettype none
// led_seq_prescaler: dwell-tick prescaler; tick flags the terminal count, which the
// owner consumes only while it is letting the counter run.
module led_seq_prescaler #(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST_CNT = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_show_sequencer.sv
`default_nettype none
// led_show_sequencer: 8-entry playlist controller driving the LED pattern generator.
// Define LED_SEQ_MANUAL_STEP_EN to add the edge-detected manual 'step' input.
module led_show_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic         loop,
  input  logic [2:0]   last_idx,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic [2:0]   pat_sel,
  output logic         speed_sel,
  output logic         gen_pause,
  output logic         gen_ena,
  output logic [2:0]   cur_idx,
  output logic         running,
  output logic         done
`ifdef LED_SEQ_MANUAL_STEP_EN
  ,
  input  logic         step
`endif
);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [DWELL_CNT_W-1:0] dwell_q, dwell_d;
  logic [PAT_W-1:0]       pat_sel_q, pat_sel_d;
  logic                   speed_sel_q, speed_sel_d;
  logic                   gen_pause_q, gen_pause_d;
  logic                   gen_ena_q, gen_ena_d;
  logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic [ENTRY_W-1:0]     table_q [ENTRIES];

  logic                   pre_clr, pre_run, tick, advance, step_rise;
  logic [ENTRY_W-1:0]     entry;

`ifdef LED_SEQ_MANUAL_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else if (ena) begin
      step_q <= step;
    end
  end

  assign step_rise = step & ~step_q;
`else
  assign step_rise = 1'b0;
`endif

  led_seq_prescaler #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (~ena),
    .clr    (pre_clr),
    .run    (pre_run),
    .tick   (tick)
  );

  assign entry = table_q[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    pat_sel_d   = pat_sel_q;
    speed_sel_d = speed_sel_q;
    gen_pause_d = gen_pause_q;
    gen_ena_d   = gen_ena_q;
    cur_idx_d   = cur_idx_q;
    running_d   = running_q;
    done_d      = 1'b0;
    pre_clr     = 1'b0;
    pre_run     = 1'b0;
    advance     = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      gen_ena_d   = 1'b0;
      gen_pause_d = 1'b0;
      running_d   = 1'b0;
    end else if (start) begin
      state_d     = ST_LOAD;
      idx_d       = '0;
      last_d      = last_idx;
      gen_pause_d = 1'b0;
      running_d   = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          pat_sel_d   = entry[PAT_LSB +: PAT_W];
          speed_sel_d = entry[SPEED_BIT];
          cur_idx_d   = idx_q;
          dwell_d     = dwell_ticks(entry);
          pre_clr     = 1'b1;
          gen_ena_d   = 1'b1;
          gen_pause_d = hold;
          state_d     = hold ? ST_HOLD : ST_RUN;
        end
        ST_RUN: begin
          if (step_rise) begin
            advance = 1'b1;
          end else if (hold) begin
            state_d     = ST_HOLD;
            gen_pause_d = 1'b1;
          end else begin
            pre_run = 1'b1;
            if (tick) begin
              if (dwell_q == DWELL_CNT_W'(1)) begin
                advance = 1'b1;
              end else begin
                dwell_d = dwell_q - 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (step_rise) begin
            advance = 1'b1;
          end else if (!hold) begin
            state_d     = ST_RUN;
            gen_pause_d = 1'b0;
          end
        end
        default: ;
      endcase

      // Entry finished: move on, wrap, or end the show.
      if (advance) begin
        gen_pause_d = 1'b0;
        if (idx_q < last_q) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end else if (loop) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          done_d    = 1'b1;
          gen_ena_d = 1'b0;
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      pat_sel_q   <= '0;
      speed_sel_q <= 1'b0;
      gen_pause_q <= 1'b0;
      gen_ena_q   <= 1'b0;
      cur_idx_q   <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      pat_sel_q   <= pat_sel_d;
      speed_sel_q <= speed_sel_d;
      gen_pause_q <= gen_pause_d;
      gen_ena_q   <= gen_ena_d;
      cur_idx_q   <= cur_idx_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // Table writes ignore ena so the host can reprogram a frozen block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= table_reset_value(IDX_W'(i));
      end
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign pat_sel   = pat_sel_q;
  assign speed_sel = speed_sel_q;
  assign gen_pause = gen_pause_q;
  assign gen_ena   = gen_ena_q;
  assign cur_idx   = cur_idx_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_show_sequencer.sv
`default_nettype none
// tb_led_show_sequencer: directed playlist scenarios plus random traffic, all checked
// every cycle against a remaining-cycles playlist model.
module tb_led_show_sequencer;

  localparam int TDIV = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [2:0] last_idx = 3'd0, wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [2:0] pat_sel, cur_idx;
  logic       speed_sel, gen_pause, gen_ena, running, done;
`ifdef LED_SEQ_MANUAL_STEP_EN
  logic       step = 1'b0;
`endif

  always #5 clk = ~clk;

  led_show_sequencer #(.TICK_DIV(TDIV), .TICK_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .hold(hold),
    .loop(loop), .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pat_sel(pat_sel), .speed_sel(speed_sel), .gen_pause(gen_pause), .gen_ena(gen_ena),
    .cur_idx(cur_idx), .running(running), .done(done)
`ifdef LED_SEQ_MANUAL_STEP_EN
    , .step(step)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Playlist model: an entry lasts a number of counting RUN cycles, tracked as one total.
  int         m_mode, m_next, m_last, m_left;
  logic [7:0] m_tab [8];
  logic [2:0] m_pat, m_cur;
  logic       m_spd, m_pause, m_gena, m_run, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] dut_outs();
    return {pat_sel, speed_sel, gen_pause, gen_ena, cur_idx, running, done};
  endfunction

  function automatic logic [10:0] model_outs();
    return {m_pat, m_spd, m_pause, m_gena, m_cur, m_run, m_done};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_next = 0; m_last = 0; m_left = 0;
    m_pat = 0; m_spd = 0; m_pause = 0; m_gena = 0; m_cur = 0; m_run = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = {4'd1, 1'b0, 3'(i)};
  endtask

  task automatic model_finish_entry();
    m_pause = 0;
    if (m_next < m_last) begin
      m_next++; m_mode = M_LOAD;
    end else if (loop) begin
      m_next = 0; m_mode = M_LOAD;
    end else begin
      m_done = 1; m_mode = M_IDLE; m_gena = 0; m_run = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] ent;
    int d;
    ent = m_tab[m_next];
    if (wr_en) m_tab[wr_addr] = wr_data;
    if (!ena) return;
    m_done = 0;
    if (stop) begin
      m_mode = M_IDLE; m_gena = 0; m_pause = 0; m_run = 0;
    end else if (start) begin
      m_mode = M_LOAD; m_next = 0; m_last = int'(last_idx); m_pause = 0; m_run = 1;
    end else if (m_mode == M_LOAD) begin
      m_pat = ent[2:0]; m_spd = ent[3]; m_cur = 3'(m_next);
      d = int'(ent[7:4]);
      if (d == 0) d = 16;
      m_left = d * TDIV;
      m_gena = 1; m_pause = hold;
      m_mode = hold ? M_HOLD : M_RUN;
    end else if (m_mode == M_RUN) begin
      if (hold) begin
        m_mode = M_HOLD; m_pause = 1;
      end else begin
        m_left--;
        if (m_left == 0) model_finish_entry();
      end
    end else if (m_mode == M_HOLD) begin
      if (!hold) begin
        m_mode = M_RUN; m_pause = 0;
      end
    end
  endtask

  task automatic step_cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag, 32'(dut_outs()), 32'(model_outs()));
    start = 0; stop = 0; wr_en = 0;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step_cycle("write");
  endtask

  initial begin
    int done_edge, n1, n2, nd;
    bit found;
    model_reset();
    ena = 1;
    #12;
    check("reset_outputs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Power-on table: entry i plays pattern i for one tick.
    last_idx = 3'd7; loop = 0; start = 1;
    step_cycle("tbl_start");
    done_edge = -1;
    for (int e = 2; e <= 45; e++) begin
      step_cycle("tbl_run");
      if (e <= 37 && (e - 2) % 5 == 0) check("tbl_pat", 32'(pat_sel), 32'((e - 2) / 5));
      if (done === 1'b1) done_edge = e;
    end
    check("tbl_done_edge", 32'(done_edge), 32'd41);

    // Asynchronous reset while running.
    start = 1;
    step_cycle("rst_start");
    for (int e = 0; e < 6; e++) step_cycle("rst_run");
    rst_n = 0;
    #2;
    check("async_reset_outs", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int e = 0; e < 3; e++) step_cycle("rst_idle");

    // Basic two-entry show.
    write_entry(3'd0, 8'h21);
    write_entry(3'd1, 8'h1A);
    last_idx = 3'd1; loop = 0; start = 1;
    step_cycle("basic_start");
    n1 = 0; n2 = 0; nd = 0; done_edge = -1;
    for (int e = 2; e <= 20; e++) begin
      step_cycle("basic_run");
      if (gen_ena && pat_sel == 3'd1 && !speed_sel) n1++;
      if (gen_ena && pat_sel == 3'd2 && speed_sel) n2++;
      if (done === 1'b1) begin nd++; done_edge = e; end
    end
    check("basic_pat1_cycles", 32'(n1), 32'd9);
    check("basic_pat2_cycles", 32'(n2), 32'd4);
    check("basic_done_count", 32'(nd), 32'd1);
    check("basic_done_edge", 32'(done_edge), 32'd15);

    // Looping a single dwell=0 entry.
    write_entry(3'd0, 8'h03);
    last_idx = 3'd0; loop = 1; start = 1;
    step_cycle("loop_start");
    nd = 0;
    for (int e = 0; e < 200; e++) begin
      step_cycle("loop_run");
      if (done === 1'b1) nd++;
    end
    check("loop_no_done", 32'(nd), 32'd0);
    check("loop_state", 32'({pat_sel, running, gen_ena}), 32'({3'd3, 1'b1, 1'b1}));
    loop = 0; stop = 1;
    step_cycle("loop_stop");

    // Hold for 10 cycles mid-entry.
    write_entry(3'd0, 8'h21);
    last_idx = 3'd0; start = 1;
    step_cycle("hold_start");
    for (int e = 2; e <= 4; e++) step_cycle("hold_pre");
    hold = 1;
    for (int e = 5; e <= 14; e++) step_cycle("hold_on");
    check("hold_pause_idx", 32'({gen_pause, cur_idx}), 32'({1'b1, 3'd0}));
    hold = 0;
    done_edge = -1;
    for (int e = 15; e <= 30; e++) begin
      step_cycle("hold_post");
      if (done === 1'b1) done_edge = e;
    end
    check("hold_done_edge", 32'(done_edge), 32'd21);

    // start+stop collision, then restart from entry 1.
    last_idx = 3'd1; start = 1;
    step_cycle("col_start");
    for (int e = 2; e <= 5; e++) step_cycle("col_run");
    start = 1; stop = 1;
    step_cycle("col_both");
    check("col_idle", 32'({running, gen_ena}), 32'd0);
    nd = 0;
    for (int e = 0; e < 20; e++) begin
      step_cycle("col_idle_run");
      if (done === 1'b1) nd++;
    end
    check("col_no_done", 32'(nd), 32'd0);
    start = 1;
    step_cycle("rs_start");
    for (int e = 2; e <= 12; e++) step_cycle("rs_run");
    check("rs_at_idx1", 32'(cur_idx), 32'd1);
    start = 1;
    step_cycle("rs_restart");
    step_cycle("rs_load");
    check("rs_idx0", 32'({cur_idx, pat_sel}), 32'({3'd0, 3'd1}));
    stop = 1;
    step_cycle("rs_stop");

    // ena low for 5 cycles, with a table write landing meanwhile.
    last_idx = 3'd0; start = 1;
    step_cycle("ena_start");
    for (int e = 2; e <= 4; e++) step_cycle("ena_pre");
    ena = 0;
    wr_en = 1; wr_addr = 3'd5; wr_data = 8'h47;
    for (int e = 5; e <= 9; e++) step_cycle("ena_off");
    ena = 1;
    done_edge = -1;
    for (int e = 10; e <= 25; e++) begin
      step_cycle("ena_post");
      if (done === 1'b1) done_edge = e;
    end
    check("ena_done_edge", 32'(done_edge), 32'd15);
    last_idx = 3'd5; start = 1;
    step_cycle("ena_tbl_start");
    found = 0;
    for (int e = 0; e < 80; e++) begin
      step_cycle("ena_tbl_run");
      if (!found && gen_ena && cur_idx == 3'd5) begin
        found = 1;
        check("ena_tbl_entry5", 32'({pat_sel, speed_sel}), 32'({3'd7, 1'b0}));
      end
    end
    check("ena_tbl_seen", 32'(found), 32'd1);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      ena = ($urandom_range(0, 19) != 0);
      start = ($urandom_range(0, 59) == 0);
      stop = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if (start) begin
        loop = 1'($urandom_range(0, 1));
        last_idx = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) begin
        wr_en = 1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 8'($urandom_range(0, 255));
      end
      step_cycle("random");
    end
    ena = 1; hold = 0; stop = 1;
    step_cycle("final_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_show_sequencer.md
Name: led_show_sequencer

Overview:
- Playlist controller that drives the LED pattern generator's pat_sel / speed_sel / pause / enable inputs.
- Steps through a programmable table of up to 8 entries. Each entry gives a pattern, a speed and a dwell time in prescaled ticks.
- Sits between the top-level pins (start/stop/hold, table write port on uio_in) and the led_pattern_generator instance.

Parameters:
- TICK_DIV, 1000000: clk cycles per dwell tick; must be >= 2.
- TICK_W, 20: prescaler counter width; must satisfy 2**TICK_W >= TICK_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; when low, all state, counters and outputs freeze (table writes still accepted)
- start  in  1  single-cycle pulse: begin playlist at entry 0
- stop  in  1  single-cycle pulse: abort to IDLE
- hold  in  1  level: freeze playback and pause the generator
- loop  in  1  level: restart at entry 0 after the last entry
- last_idx  in  3  index of final playlist entry; sampled on start
- wr_en  in  1  table write strobe
- wr_addr  in  3  table entry index
- wr_data  in  8  entry: [2:0] pattern, [3] speed, [7:4] dwell ticks (0 means 16)
- pat_sel  out  3  to generator
- speed_sel  out  1  to generator
- gen_pause  out  1  to generator
- gen_ena  out  1  to generator
- cur_idx  out  3  active entry index
- running  out  1  high in LOAD/RUN/HOLD
- done  out  1  one-cycle pulse when a non-loop playlist finishes

Behaviour:
- Reset values (async, rst_n low): all outputs 0, state IDLE, prescaler 0, dwell counter 0.
- Table reset value: entry i = {4'd1, 1'b0, i[2:0]}.
- All outputs are registered.
- Table write: takes effect at the next edge, in any state.
  - Writing the active entry affects only its next LOAD.
- States and transitions:
  - IDLE: gen_ena=0, gen_pause=0, running=0. start -> LOAD with idx=0; last_idx is latched.
  - LOAD: one cycle. On exit edge, pat_sel/speed_sel/cur_idx take the entry fields; dwell counter = dwell (0 -> 16); prescaler = 0; gen_ena=1. Next state RUN.
  - RUN: prescaler counts 0..TICK_DIV-1; tick is asserted when it equals TICK_DIV-1. Each tick decrements dwell. When the tick arrives with dwell==1:
    - idx < last_idx: idx+1, go to LOAD.
    - idx == last_idx and loop=1: idx=0, go to LOAD.
    - idx == last_idx and loop=0: done=1 for one cycle, go to IDLE; gen_ena and running fall on the same edge.
  - HOLD: entered from RUN when hold=1. Prescaler and dwell counter frozen; gen_pause=1. Returns to RUN when hold=0, resuming at the frozen counts.
- hold during LOAD: LOAD completes, then the state enters HOLD.
- Priority: rst_n > ena low (freeze) > stop > start > hold > tick.
- stop in any state -> IDLE next edge; done is not pulsed.
- start while running -> restarts at LOAD, idx=0, last_idx re-latched.
- start and stop in the same cycle: stop wins.
- Entry timing: start at edge k gives outputs valid after edge k+2. Each entry holds for dwell*TICK_DIV RUN cycles + 1 LOAD cycle.
- Pattern change is glitch-free: pat_sel and speed_sel change only on a LOAD exit edge.

Optional Feature:
- Macro: LED_SEQ_MANUAL_STEP_EN.
- With the macro: adds input step (level), which the block edge-detects internally with a 1-cycle register.
  - A rising edge in RUN or HOLD forces an immediate advance, exactly as if the dwell had expired: next/loop/done rules apply and the state goes to LOAD or IDLE.
  - stop has priority over step; step has priority over hold.
- Without the macro: no step port; advance happens only on dwell expiry.

Decomposition:
- Package led_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, HOLD)
  - entry field positions/widths
  - DWELL_ZERO_MEANS = 16
  - table reset-value function
- One sub-module, led_seq_prescaler: counter with clear and freeze inputs, emits a one-cycle tick.
- Table storage is an 8x8 register array kept in the main module.

Test Plan (TICK_DIV=4):
- Reset mid-RUN: assert rst_n=0 while running -> outputs 0 immediately (async). After release, state is IDLE and the table holds its reset contents.
- Basic sequence: write entry0=8'h21 and entry1=8'h1A, last_idx=1, loop=0, pulse start.
  - pat_sel=1, speed=0 after edge k+2 for 8 cycles.
  - Then one LOAD cycle, then pat_sel=2, speed=1 for 4 cycles.
  - Then done pulses once and gen_ena=0.
- Loop and dwell=0: entry0=8'h03, last_idx=0, loop=1 -> pat_sel=3 is re-LOADed every 65 cycles; done never asserts.
- Hold: hold=1 for 10 cycles mid-entry -> gen_pause=1, cur_idx unchanged, and the remaining dwell resumes exactly where it stopped.
- Stop/start collisions:
  - start and stop in the same cycle during RUN -> IDLE, no done pulse.
  - start during RUN at idx=1 -> LOAD of idx 0 next edge.
- ena low: deassert ena for 5 cycles during RUN -> all outputs and counters are unchanged, and the total entry duration extends by exactly 5 cycles. A table write issued while ena=0 is still stored.
